phy_tx_serializer_n: RTL and testbench
======================================

Name: phy_tx_serializer_n

Overview:
- Parametrised successor to the fixed 4-lane, 8-bit PHY transmit path.
- Accepts one frame of LANES words of WIDTH bits through a ready/valid-style handshake and byte-stripes the enabled lanes, in ascending order, onto a single serial line.
- Runs entirely in the bit-rate clock domain. Inserts COM symbols for invalid lanes and sends a COM sync preamble after reset.
- Echoes each captured frame on recirc outputs for the downstream checker; sits between the lane mux stage and the line driver.

Parameters:
- LANES, 4: number of parallel input lanes (1–8).
- WIDTH, 8: bits per symbol (4–16).
- COM, 8'hBC: idle/sync symbol, WIDTH bits.
- SYNC_COUNT, 4: COM symbols sent after reset before the first capture (≥1).
- MSB_FIRST, 1: 1 = each symbol sent MSB first; 0 = LSB first.

Ports:
- clk_32f  in  1  bit-rate clock (32× word rate at defaults); the only clock.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  LANES*WIDTH  flattened lane words; lane i occupies bits [i*WIDTH +: WIDTH].
- valid_in  in  LANES  per-lane valid.
- lane_en  in  LANES  active-lane mask; sampled only at capture.
- in_ready  out  1  high in the cycle whose rising edge captures data_in/valid_in/lane_en.
- data_out  out  1  serial line, registered.
- symbol_start  out  1  high while data_out carries bit 0 of any symbol.
- sync_done  out  1  high from the first frame capture until reset.
- recirc_out  out  LANES*WIDTH  echo of the last captured frame.
- recirc_valid  out  LANES  echo of the last captured valid, ANDed with the effective lane_en.

Behaviour:
- Reset asserted (asynchronous): data_out, in_ready, symbol_start, sync_done = 0; recirc_out and recirc_valid = 0; FSM = SYNC with counters cleared.
- Reset asserted mid-frame: the frame is aborted and discarded; the block restarts from SYNC after release.
- FSM states:
  - SYNC: transmits COM SYNC_COUNT times, i.e. SYNC_COUNT*WIDTH bit cycles.
  - ACTIVE: transmits the captured frame.
  - SYNC → ACTIVE at the capture edge following the last sync bit. ACTIVE → ACTIVE on every frame boundary. There is no return to SYNC except through reset.
- Timing from reset release:
  - Edge 1 drives the first sync bit onto data_out.
  - in_ready is high in the cycle before edge SYNC_COUNT*WIDTH+1; that edge performs the first capture.
  - sync_done rises on that same edge.
- Capture rules:
  - A frame is captured on every edge where in_ready=1. The upstream must present stable inputs in that cycle; there is no stall.
  - Effective mask = lane_en, or lane 0 alone when lane_en == 0.
  - Frame length F = popcount(effective mask) * WIDTH bits.
- in_ready timing: high during the last bit cycle of each frame, or of the sync preamble; low otherwise. Frames are back-to-back with no bubble, so in_ready pulses exactly once every F cycles.
- Latency: the first bit of a captured frame appears on data_out immediately after the capture edge, i.e. 1 cycle.
- Bit ordering: enabled lanes go out in ascending index. Each lane sends data_in[lane] if valid_in[lane]=1, else COM. Bit order within a symbol follows MSB_FIRST.
- Recirc:
  - recirc_out and recirc_valid update on the capture edge and hold until the next capture.
  - Lanes that are invalid or masked report recirc_valid=0 and zero data.
- Counters:
  - Bit counter is clog2(WIDTH) bits and wraps at WIDTH-1.
  - Lane pointer skips masked lanes and wraps to the lowest enabled lane.
  - Sync counter is clog2(SYNC_COUNT+1) bits.
- Changes to lane_en or valid_in between captures are ignored.

Decomposition:
- Shared package phy_tx_pkg:
  - default COM value (8'hBC);
  - a clog2 function;
  - FSM state encoding {SYNC, ACTIVE};
  - a popcount function for the lane mask.
- One sub-module: phy_piso_n, a WIDTH-bit parallel-in/serial-out register with a load strobe, a MSB_FIRST parameter and a last-bit flag. The top level owns the FSM, lane pointer, COM substitution, handshake and recirc.

Test Plan:
1. Defaults; hold reset_L low 5 cycles, then release → data_out = 10111100 repeated 4× over edges 1–32; in_ready high only in the cycle before edge 33; sync_done rises at edge 33; symbol_start is high at edges 1, 9, 17, 25.
2. lane_en=1111, valid_in=1111, data 0x01/0x02/0x03/0x04 → serial 00000001 00000010 00000011 00000100; next in_ready exactly 32 cycles after the previous one; recirc_valid=1111.
3. valid_in=0101, data 0xAA/0x55/0xFF/0x00 → AA, BC, FF, BC on the line; recirc_valid=0101; recirc lanes 1 and 3 read 0x00.
4. Mask behaviour:
   - lane_en=0010, lane 1 = 0xF0 → 11110000 per frame; in_ready every 8 cycles.
   - lane_en=0000 → lane 0 data is sent with 8-bit frames.
5. Assert reset_L at bit 13 of a frame → all outputs 0 without waiting for a clock edge; after release, the full 32-bit COM preamble is sent again and the aborted frame is never emitted.
6. LANES=2, WIDTH=10, COM=10'h17C, MSB_FIRST=0, lane 0 = 10'h001, lane 1 invalid → 1000000000 then 0011111010; in_ready every 20 cycles.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// Shared definitions for the parametrised PHY transmit serializer.
package phy_tx_pkg;

  // Idle / sync symbol used when the instantiating level does not override it.
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

  // Serializer modes: COM preamble after reset, then back-to-back frames.
  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Number of enabled lanes in a mask (up to 8 lanes).
  function automatic int popcount(input logic [7:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/phy_tx_serializer_n_piso.sv
// WIDTH-bit parallel-in/serial-out register. A load drives the first bit of
// the new symbol onto the output on the same edge; otherwise it keeps shifting.
module phy_piso_n
  import phy_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o,
  output logic             first_o,
  output logic             last_o
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             first_q, first_d;

  // Next-state: load a fresh symbol or emit the next buffered bit.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    first_d = 1'b0;
    if (load_i) begin
      cnt_d   = '0;
      first_d = 1'b1;
      if (MSB_FIRST) begin
        bit_d   = data_i[WIDTH-1];
        shreg_d = data_i << 1;
      end else begin
        bit_d   = data_i[0];
        shreg_d = data_i >> 1;
      end
    end else begin
      cnt_d = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
      if (MSB_FIRST) begin
        bit_d   = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end else begin
        bit_d   = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
    end
  end

  // Shift state, bit counter and registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      first_q <= first_d;
    end
  end

  assign bit_o   = bit_q;
  assign first_o = first_q;
  assign last_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/phy_tx_serializer_n.sv
// Multi-lane PHY transmit serializer: COM preamble after reset, then captured
// frames of enabled lanes sent back-to-back on one serial line.
module phy_tx_serializer_n
  import phy_tx_pkg::*;
#(
  parameter int               LANES      = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_DEFAULT),
  parameter int               SYNC_COUNT = 4,
  parameter bit               MSB_FIRST  = 1'b1
) (
  input  logic                   clk_32f,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  input  logic [LANES-1:0]       lane_en,
  output logic                   in_ready,
  output logic                   data_out,
  output logic                   symbol_start,
  output logic                   sync_done,
  output logic [LANES*WIDTH-1:0] recirc_out,
  output logic [LANES-1:0]       recirc_valid
);

  localparam int LW = (LANES > 1) ? clog2(LANES) : 1;
  localparam int SW = clog2(SYNC_COUNT + 1);

  tx_state_e                    state_q, state_d;
  logic                         started_q, started_d;
  logic [SW-1:0]                sync_cnt_q, sync_cnt_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [LANES-1:0]             mask_q;
  logic [LANES-1:0][WIDTH-1:0]  sym_q;
  logic [LANES-1:0][WIDTH-1:0]  recirc_q;
  logic [LANES-1:0]             recirc_valid_q;
  logic                         sync_done_q;

  logic [LANES-1:0]             eff_mask;
  logic [LANES-1:0][WIDTH-1:0]  cap_sym;
  logic [LANES-1:0][WIDTH-1:0]  rec_data_d;
  logic [LW-1:0]                first_lane;
  logic [LW-1:0]                next_lane;
  logic                         last_lane;
  logic                         piso_last;
  logic                         capture;
  logic                         load;
  logic [WIDTH-1:0]             load_sym;

  // An empty mask falls back to lane 0 so a frame is never zero-length.
  assign eff_mask = (lane_en == '0) ? LANES'(1) : lane_en;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign cap_sym[gi]    = valid_in[gi] ? data_in[gi*WIDTH +: WIDTH] : COM;
    assign rec_data_d[gi] = (valid_in[gi] && eff_mask[gi]) ? data_in[gi*WIDTH +: WIDTH] : '0;
  end

  // Lowest enabled lane of the incoming mask and next enabled lane of the frame.
  always_comb begin
    first_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (eff_mask[i]) first_lane = LW'(i);
    end
    next_lane = lane_q;
    last_lane = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (last_lane && mask_q[i] && (i > int'(lane_q))) begin
        next_lane = LW'(i);
        last_lane = 1'b0;
      end
    end
  end

  // Ready in the last bit cycle of the preamble or of a frame.
  assign capture = started_q && piso_last &&
                   ((state_q == ST_SYNC) ? (sync_cnt_q == SW'(SYNC_COUNT)) : last_lane);

  // Sequencing: choose which symbol the serializer loads at each boundary.
  always_comb begin
    state_d    = state_q;
    started_d  = started_q;
    sync_cnt_d = sync_cnt_q;
    lane_d     = lane_q;
    load       = 1'b0;
    load_sym   = COM;
    if (!started_q) begin
      load       = 1'b1;
      started_d  = 1'b1;
      sync_cnt_d = SW'(1);
    end else if (capture) begin
      load     = 1'b1;
      load_sym = cap_sym[first_lane];
      state_d  = ST_ACTIVE;
      lane_d   = first_lane;
    end else if (piso_last) begin
      load = 1'b1;
      if (state_q == ST_SYNC) begin
        sync_cnt_d = sync_cnt_q + 1'b1;
      end else begin
        load_sym = sym_q[next_lane];
        lane_d   = next_lane;
      end
    end
  end

  // FSM, preamble counter and lane pointer.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_SYNC;
      started_q  <= 1'b0;
      sync_cnt_q <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      sync_cnt_q <= sync_cnt_d;
      lane_q     <= lane_d;
    end
  end

  // Frame buffer and recirc echo, both refreshed only on a capture edge.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      mask_q         <= '0;
      sym_q          <= '0;
      recirc_q       <= '0;
      recirc_valid_q <= '0;
      sync_done_q    <= 1'b0;
    end else if (capture) begin
      mask_q         <= eff_mask;
      sym_q          <= cap_sym;
      recirc_q       <= rec_data_d;
      recirc_valid_q <= valid_in & eff_mask;
      sync_done_q    <= 1'b1;
    end
  end

  phy_piso_n #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk_32f),
    .rst_n   (reset_L),
    .load_i  (load),
    .data_i  (load_sym),
    .bit_o   (data_out),
    .first_o (symbol_start),
    .last_o  (piso_last)
  );

  assign in_ready     = capture;
  assign sync_done    = sync_done_q;
  assign recirc_out   = recirc_q;
  assign recirc_valid = recirc_valid_q;

endmodule

// File: tb/tb_phy_tx_serializer_n.sv
// Directed bench for phy_tx_serializer_n: default build plus a 2-lane,
// 10-bit, LSB-first build.
module tb_phy_tx_serializer_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        reset_L;
  logic [31:0] data_in;
  logic [3:0]  valid_in, lane_en;
  logic        in_ready, data_out, symbol_start, sync_done;
  logic [31:0] recirc_out;
  logic [3:0]  recirc_valid;

  // 2-lane, 10-bit, LSB-first instance
  logic        reset2_L;
  logic [19:0] data_in2;
  logic [1:0]  valid_in2, lane_en2;
  logic        in_ready2, data_out2, symbol_start2, sync_done2;
  logic [19:0] recirc_out2;
  logic [1:0]  recirc_valid2;

  int total = 0;
  int bad   = 0;
  logic [63:0] ser_v, rdy_v, sst_v;

  phy_tx_serializer_n dut (
    .clk_32f      (clk),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .lane_en      (lane_en),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .symbol_start (symbol_start),
    .sync_done    (sync_done),
    .recirc_out   (recirc_out),
    .recirc_valid (recirc_valid)
  );

  phy_tx_serializer_n #(
    .LANES      (2),
    .WIDTH      (10),
    .COM        (10'h17C),
    .SYNC_COUNT (4),
    .MSB_FIRST  (1'b0)
  ) dut2 (
    .clk_32f      (clk),
    .reset_L      (reset2_L),
    .data_in      (data_in2),
    .valid_in     (valid_in2),
    .lane_en      (lane_en2),
    .in_ready     (in_ready2),
    .data_out     (data_out2),
    .symbol_start (symbol_start2),
    .sync_done    (sync_done2),
    .recirc_out   (recirc_out2),
    .recirc_valid (recirc_valid2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_vecs();
    ser_v = '0;
    rdy_v = '0;
    sst_v = '0;
  endtask

  // Sample n bit cycles, #1 after each rising edge, appending to the vectors.
  task automatic collect(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (which == 1) begin
        ser_v = {ser_v[62:0], data_out};
        rdy_v = {rdy_v[62:0], in_ready};
        sst_v = {sst_v[62:0], symbol_start};
      end else begin
        ser_v = {ser_v[62:0], data_out2};
        rdy_v = {rdy_v[62:0], in_ready2};
        sst_v = {sst_v[62:0], symbol_start2};
      end
    end
    $display("dut%0d: %0d bits ser=%h rdy=%h sst=%h", which, n, ser_v, rdy_v, sst_v);
  endtask

  initial begin
    reset_L   = 1'b1;
    reset2_L  = 1'b1;
    data_in   = 32'h04030201;
    valid_in  = 4'b1111;
    lane_en   = 4'b1111;
    data_in2  = {10'h3FF, 10'h001};
    valid_in2 = 2'b01;
    lane_en2  = 2'b11;
    #1;
    reset_L  = 1'b0;
    reset2_L = 1'b0;
    #3;
    // Reset state before any clock edge
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_symbol_start", 64'(symbol_start), 64'h0);
    check("rst_sync_done", 64'(sync_done), 64'h0);
    check("rst_recirc_out", 64'(recirc_out), 64'h0);
    check("rst_recirc_valid", 64'(recirc_valid), 64'h0);

    // 1: preamble after 5 reset cycles
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    clear_vecs();
    collect(1, 32);
    check("t1_preamble", ser_v, 64'hBCBCBCBC);
    check("t1_in_ready", rdy_v, 64'h1);
    check("t1_symbol_start", sst_v, 64'h80808080);
    check("t1_sync_done_low", 64'(sync_done), 64'h0);

    // 2: all lanes valid
    clear_vecs();
    collect(1, 32);
    check("t2_serial", ser_v, 64'h01020304);
    check("t2_in_ready", rdy_v, 64'h1);
    check("t2_symbol_start", sst_v, 64'h80808080);
    check("t2_sync_done", 64'(sync_done), 64'h1);
    check("t2_recirc_valid", 64'(recirc_valid), 64'hF);
    check("t2_recirc_out", 64'(recirc_out), 64'h04030201);

    // 3: lanes 1 and 3 invalid, inputs disturbed mid-frame
    data_in  = 32'h00FF55AA;
    valid_in = 4'b0101;
    clear_vecs();
    collect(1, 8);
    data_in  = 32'h12345678;
    valid_in = 4'b1111;
    lane_en  = 4'b0001;
    collect(1, 24);
    check("t3_serial", ser_v, 64'hAABCFFBC);
    check("t3_in_ready", rdy_v, 64'h1);
    check("t3_recirc_valid", 64'(recirc_valid), 64'h5);
    check("t3_recirc_out", 64'(recirc_out), 64'h00FF00AA);

    // 4a: only lane 1 enabled
    data_in  = 32'h0000F000;
    valid_in = 4'b0010;
    lane_en  = 4'b0010;
    clear_vecs();
    collect(1, 16);
    check("t4a_serial", ser_v, 64'hF0F0);
    check("t4a_in_ready", rdy_v, 64'h0101);
    check("t4a_recirc_valid", 64'(recirc_valid), 64'h2);
    check("t4a_recirc_out", 64'(recirc_out), 64'h0000F000);

    // 4b: empty mask falls back to lane 0
    data_in  = 32'h3322115A;
    valid_in = 4'b0001;
    lane_en  = 4'b0000;
    clear_vecs();
    collect(1, 16);
    check("t4b_serial", ser_v, 64'h5A5A);
    check("t4b_in_ready", rdy_v, 64'h0101);
    check("t4b_recirc_valid", 64'(recirc_valid), 64'h1);
    check("t4b_recirc_out", 64'(recirc_out), 64'h0000005A);

    // 5: reset in the middle of a frame
    data_in  = 32'hDEADBEEF;
    valid_in = 4'b1111;
    lane_en  = 4'b1111;
    clear_vecs();
    collect(1, 13);
    check("t5_partial", ser_v, 64'b1110111110111);
    reset_L = 1'b0;
    #1;
    check("t5_async_data_out", 64'(data_out), 64'h0);
    check("t5_async_in_ready", 64'(in_ready), 64'h0);
    check("t5_async_symbol_start", 64'(symbol_start), 64'h0);
    check("t5_async_sync_done", 64'(sync_done), 64'h0);
    check("t5_async_recirc_out", 64'(recirc_out), 64'h0);
    check("t5_async_recirc_valid", 64'(recirc_valid), 64'h0);
    data_in = 32'h44332211;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    clear_vecs();
    collect(1, 32);
    check("t5_preamble", ser_v, 64'hBCBCBCBC);
    check("t5_preamble_ready", rdy_v, 64'h1);
    check("t5_sync_done_low", 64'(sync_done), 64'h0);
    clear_vecs();
    collect(1, 32);
    check("t5_frame", ser_v, 64'h11223344);
    check("t5_frame_ready", rdy_v, 64'h1);

    // 6: 2 lanes, 10 bits, LSB first, lane 1 invalid
    check("t6_rst_data_out", 64'(data_out2), 64'h0);
    check("t6_rst_sync_done", 64'(sync_done2), 64'h0);
    @(negedge clk);
    reset2_L = 1'b1;
    clear_vecs();
    collect(2, 40);
    check("t6_preamble", ser_v, 64'({4{10'b0011111010}}));
    check("t6_preamble_ready", rdy_v, 64'h1);
    check("t6_preamble_sst", sst_v, 64'({4{10'b1000000000}}));
    clear_vecs();
    collect(2, 20);
    check("t6_frame1", ser_v, 64'({10'b1000000000, 10'b0011111010}));
    check("t6_frame1_ready", rdy_v, 64'h1);
    check("t6_frame1_sst", sst_v, 64'({2{10'b1000000000}}));
    clear_vecs();
    collect(2, 20);
    check("t6_frame2", ser_v, 64'({10'b1000000000, 10'b0011111010}));
    check("t6_frame2_ready", rdy_v, 64'h1);
    check("t6_recirc_valid", 64'(recirc_valid2), 64'h1);
    check("t6_recirc_out", 64'(recirc_out2), 64'h00001);
    check("t6_sync_done", 64'(sync_done2), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
